// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with valid tracking, stall hold, flush bubbles and saturating perf counters
// Ports: clock/reset (sync, active-high, sampled on the edge chosen by NEG_EDGE); stall holds everything;
//  flush loads a bubble; valid marks a real decode instruction; clr_cnt zeroes both counters.
//  Datapath (PC4, dadoRs, dadoRt, sinalExtendido), address (rt_mux, rd_mux, rs_fw, rt_fw) and control
//  (ALUOp, regDst, branch, memRead, memtoReg, memWrite, ALUSrc, regWrite) inputs each have a registered
//  *_out copy; valid_out tracks the EX instruction; bubble_cnt/stall_cnt count bubble and stall edges.
module idex_pipe_reg #(
   parameter int DATA_W   = 32,
   parameter int REG_A_W  = 5,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 16,
   parameter bit NEG_EDGE = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               valid,
   input  logic               clr_cnt,
   input  logic [DATA_W-1:0]  PC4,
   input  logic [DATA_W-1:0]  dadoRs,
   input  logic [DATA_W-1:0]  dadoRt,
   input  logic [DATA_W-1:0]  sinalExtendido,
   input  logic [REG_A_W-1:0] rt_mux,
   input  logic [REG_A_W-1:0] rd_mux,
   input  logic [REG_A_W-1:0] rs_fw,
   input  logic [REG_A_W-1:0] rt_fw,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic               regDst,
   input  logic               branch,
   input  logic               memRead,
   input  logic               memtoReg,
   input  logic               memWrite,
   input  logic               ALUSrc,
   input  logic               regWrite,
   output logic [DATA_W-1:0]  PC4_out,
   output logic [DATA_W-1:0]  dadoRs_out,
   output logic [DATA_W-1:0]  dadoRt_out,
   output logic [DATA_W-1:0]  sinalExtendido_out,
   output logic [REG_A_W-1:0] rt_mux_out,
   output logic [REG_A_W-1:0] rd_mux_out,
   output logic [REG_A_W-1:0] rs_fw_out,
   output logic [REG_A_W-1:0] rt_fw_out,
   output logic [ALUOP_W-1:0] ALUOp_out,
   output logic               regDst_out,
   output logic               branch_out,
   output logic               memRead_out,
   output logic               memtoReg_out,
   output logic               memWrite_out,
   output logic               ALUSrc_out,
   output logic               regWrite_out,
   output logic               valid_out,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   stall_cnt
);
   localparam int DW = 4*DATA_W + 4*REG_A_W;
   localparam int CW = ALUOP_W + 7;
   localparam logic [CNT_W-1:0] ONE = 1;
   logic [DW-1:0]    in_dat, dat_d, dat_q;
   logic [CW-1:0]    in_ctl, ctl_d, ctl_q;
   logic             vld_d, vld_q;
   logic [CNT_W-1:0] bub_d, bub_q, stl_d, stl_q;
   logic             load, bub_inc, stl_inc;
   assign in_dat = {PC4, dadoRs, dadoRt, sinalExtendido, rt_mux, rd_mux, rs_fw, rt_fw};
   assign in_ctl = {ALUOp, regDst, branch, memRead, memtoReg, memWrite, ALUSrc, regWrite};
   always_comb begin
      load    = !flush && !stall;
      // flush keeps datapath/address fields; only control and valid are squashed
      dat_d   = load ? in_dat : dat_q;
      ctl_d   = flush ? '0 : stall ? ctl_q : valid ? in_ctl : '0;
      vld_d   = flush ? 1'b0 : stall ? vld_q : valid;
      bub_inc = flush || (load && !valid);
      stl_inc = !flush && stall;
      bub_d   = clr_cnt ? '0 : (bub_inc && bub_q != '1) ? bub_q + ONE : bub_q;
      stl_d   = clr_cnt ? '0 : (stl_inc && stl_q != '1) ? stl_q + ONE : stl_q;
   end
   if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clock) begin
         if (reset) begin
            dat_q <= '0;
            ctl_q <= '0;
            vld_q <= 1'b0;
            bub_q <= '0;
            stl_q <= '0;
         end else begin
            dat_q <= dat_d;
            ctl_q <= ctl_d;
            vld_q <= vld_d;
            bub_q <= bub_d;
            stl_q <= stl_d;
         end
      end
   end else begin : g_pos
      always_ff @(posedge clock) begin
         if (reset) begin
            dat_q <= '0;
            ctl_q <= '0;
            vld_q <= 1'b0;
            bub_q <= '0;
            stl_q <= '0;
         end else begin
            dat_q <= dat_d;
            ctl_q <= ctl_d;
            vld_q <= vld_d;
            bub_q <= bub_d;
            stl_q <= stl_d;
         end
      end
   end
   assign {PC4_out, dadoRs_out, dadoRt_out, sinalExtendido_out,
           rt_mux_out, rd_mux_out, rs_fw_out, rt_fw_out} = dat_q;
   assign {ALUOp_out, regDst_out, branch_out, memRead_out, memtoReg_out,
           memWrite_out, ALUSrc_out, regWrite_out} = ctl_q;
   assign valid_out  = vld_q;
   assign bubble_cnt = bub_q;
   assign stall_cnt  = stl_q;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed checks of idex_pipe_reg on both capture edges
module tb_idex_pipe_reg;
   logic clock = 1'b0;
   logic reset, stall, flush, valid, clr_cnt;
   logic [31:0] PC4, dadoRs, dadoRt, sinalExtendido;
   logic [4:0]  rt_mux, rd_mux, rs_fw, rt_fw;
   logic [1:0]  ALUOp;
   logic regDst, branch, memRead, memtoReg, memWrite, ALUSrc, regWrite;
   logic [31:0] p_pc4, p_rs, p_rt, p_se, n_pc4, n_rs, n_rt, n_se;
   logic [4:0]  p_rtm, p_rdm, p_rsf, p_rtf, n_rtm, n_rdm, n_rsf, n_rtf;
   logic [1:0]  p_aluop, n_aluop;
   logic p_rdst, p_br, p_mrd, p_m2r, p_mwr, p_asrc, p_rwr, p_vld;
   logic n_rdst, n_br, n_mrd, n_m2r, n_mwr, n_asrc, n_rwr, n_vld;
   logic [3:0]  p_bub, p_stl, n_bub, n_stl;
   int n_chk = 0, n_err = 0;
   always #5 clock = ~clock;
   idex_pipe_reg #(.CNT_W(4), .NEG_EDGE(1'b0)) dut_p (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid(valid), .clr_cnt(clr_cnt),
      .PC4(PC4), .dadoRs(dadoRs), .dadoRt(dadoRt), .sinalExtendido(sinalExtendido),
      .rt_mux(rt_mux), .rd_mux(rd_mux), .rs_fw(rs_fw), .rt_fw(rt_fw), .ALUOp(ALUOp),
      .regDst(regDst), .branch(branch), .memRead(memRead), .memtoReg(memtoReg),
      .memWrite(memWrite), .ALUSrc(ALUSrc), .regWrite(regWrite),
      .PC4_out(p_pc4), .dadoRs_out(p_rs), .dadoRt_out(p_rt), .sinalExtendido_out(p_se),
      .rt_mux_out(p_rtm), .rd_mux_out(p_rdm), .rs_fw_out(p_rsf), .rt_fw_out(p_rtf),
      .ALUOp_out(p_aluop), .regDst_out(p_rdst), .branch_out(p_br), .memRead_out(p_mrd),
      .memtoReg_out(p_m2r), .memWrite_out(p_mwr), .ALUSrc_out(p_asrc), .regWrite_out(p_rwr),
      .valid_out(p_vld), .bubble_cnt(p_bub), .stall_cnt(p_stl));
   idex_pipe_reg #(.CNT_W(4), .NEG_EDGE(1'b1)) dut_n (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid(valid), .clr_cnt(clr_cnt),
      .PC4(PC4), .dadoRs(dadoRs), .dadoRt(dadoRt), .sinalExtendido(sinalExtendido),
      .rt_mux(rt_mux), .rd_mux(rd_mux), .rs_fw(rs_fw), .rt_fw(rt_fw), .ALUOp(ALUOp),
      .regDst(regDst), .branch(branch), .memRead(memRead), .memtoReg(memtoReg),
      .memWrite(memWrite), .ALUSrc(ALUSrc), .regWrite(regWrite),
      .PC4_out(n_pc4), .dadoRs_out(n_rs), .dadoRt_out(n_rt), .sinalExtendido_out(n_se),
      .rt_mux_out(n_rtm), .rd_mux_out(n_rdm), .rs_fw_out(n_rsf), .rt_fw_out(n_rtf),
      .ALUOp_out(n_aluop), .regDst_out(n_rdst), .branch_out(n_br), .memRead_out(n_mrd),
      .memtoReg_out(n_m2r), .memWrite_out(n_mwr), .ALUSrc_out(n_asrc), .regWrite_out(n_rwr),
      .valid_out(n_vld), .bubble_cnt(n_bub), .stall_cnt(n_stl));
   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cmp2(input string tag, input logic [31:0] op, input logic [31:0] on, input logic [31:0] exp);
      cmp({tag, "_pos"}, op, exp);
      cmp({tag, "_neg"}, on, exp);
   endtask
   // one step = one posedge and one negedge, i.e. one active edge for each instance
   task automatic step(input int k = 1);
      for (int i = 0; i < k; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
      #1;
   endtask
   initial begin
      reset = 1; stall = 1; flush = 1; valid = 1; clr_cnt = 1;
      PC4 = '1; dadoRs = '1; dadoRt = '1; sinalExtendido = '1;
      rt_mux = '1; rd_mux = '1; rs_fw = '1; rt_fw = '1; ALUOp = '1;
      regDst = 1; branch = 1; memRead = 1; memtoReg = 1; memWrite = 1; ALUSrc = 1; regWrite = 1;
      step(2);
      cmp2("rst_pc4", p_pc4, n_pc4, 0);
      cmp2("rst_rs", p_rs, n_rs, 0);
      cmp2("rst_rtfw", 32'(p_rtf), 32'(n_rtf), 0);
      cmp2("rst_aluop", 32'(p_aluop), 32'(n_aluop), 0);
      cmp2("rst_rwr", 32'(p_rwr), 32'(n_rwr), 0);
      cmp2("rst_vld", 32'(p_vld), 32'(n_vld), 0);
      cmp2("rst_bub", 32'(p_bub), 32'(n_bub), 0);
      cmp2("rst_stl", 32'(p_stl), 32'(n_stl), 0);
      reset = 0; stall = 0; flush = 0; valid = 1; clr_cnt = 0;
      PC4 = 32'h4; dadoRs = 32'hDEADBEEF; dadoRt = 32'h11111111; sinalExtendido = 32'hFFFFFFF0;
      rt_mux = 5'd3; rd_mux = 5'd7; rs_fw = 5'd9; rt_fw = 5'd31; ALUOp = 2'b10;
      regDst = 1; branch = 0; memRead = 0; memtoReg = 0; memWrite = 0; ALUSrc = 1; regWrite = 1;
      step();
      cmp2("ld_pc4", p_pc4, n_pc4, 32'h4);
      cmp2("ld_rs", p_rs, n_rs, 32'hDEADBEEF);
      cmp2("ld_se", p_se, n_se, 32'hFFFFFFF0);
      cmp2("ld_rdm", 32'(p_rdm), 32'(n_rdm), 7);
      cmp2("ld_rtfw", 32'(p_rtf), 32'(n_rtf), 31);
      cmp2("ld_aluop", 32'(p_aluop), 32'(n_aluop), 2);
      cmp2("ld_rwr", 32'(p_rwr), 32'(n_rwr), 1);
      cmp2("ld_asrc", 32'(p_asrc), 32'(n_asrc), 1);
      cmp2("ld_vld", 32'(p_vld), 32'(n_vld), 1);
      cmp2("ld_bub", 32'(p_bub), 32'(n_bub), 0);
      PC4 = 32'h8; dadoRs = 32'h12345678; regWrite = 0; ALUOp = 2'b01;
      #2;
      cmp2("between_pc4", p_pc4, n_pc4, 32'h4);
      cmp2("between_rs", p_rs, n_rs, 32'hDEADBEEF);
      stall = 1;
      step(3);
      cmp2("stl_pc4", p_pc4, n_pc4, 32'h4);
      cmp2("stl_rs", p_rs, n_rs, 32'hDEADBEEF);
      cmp2("stl_rwr", 32'(p_rwr), 32'(n_rwr), 1);
      cmp2("stl_aluop", 32'(p_aluop), 32'(n_aluop), 2);
      cmp2("stl_vld", 32'(p_vld), 32'(n_vld), 1);
      cmp2("stl_cnt", 32'(p_stl), 32'(n_stl), 3);
      cmp2("stl_bub", 32'(p_bub), 32'(n_bub), 0);
      flush = 1; regWrite = 1; memWrite = 1; memRead = 1; branch = 1;
      step();
      cmp2("fl_vld", 32'(p_vld), 32'(n_vld), 0);
      cmp2("fl_rwr", 32'(p_rwr), 32'(n_rwr), 0);
      cmp2("fl_mwr", 32'(p_mwr), 32'(n_mwr), 0);
      cmp2("fl_mrd", 32'(p_mrd), 32'(n_mrd), 0);
      cmp2("fl_br", 32'(p_br), 32'(n_br), 0);
      cmp2("fl_aluop", 32'(p_aluop), 32'(n_aluop), 0);
      cmp2("fl_rs", p_rs, n_rs, 32'hDEADBEEF);
      cmp2("fl_pc4", p_pc4, n_pc4, 32'h4);
      cmp2("fl_bub", 32'(p_bub), 32'(n_bub), 1);
      cmp2("fl_stl", 32'(p_stl), 32'(n_stl), 3);
      flush = 0; stall = 0; valid = 0;
      step();
      cmp2("nv_pc4", p_pc4, n_pc4, 32'h8);
      cmp2("nv_rs", p_rs, n_rs, 32'h12345678);
      cmp2("nv_rwr", 32'(p_rwr), 32'(n_rwr), 0);
      cmp2("nv_mwr", 32'(p_mwr), 32'(n_mwr), 0);
      cmp2("nv_vld", 32'(p_vld), 32'(n_vld), 0);
      cmp2("nv_bub", 32'(p_bub), 32'(n_bub), 2);
      flush = 1;
      step(20);
      cmp2("sat_bub", 32'(p_bub), 32'(n_bub), 15);
      cmp2("sat_stl", 32'(p_stl), 32'(n_stl), 3);
      clr_cnt = 1;
      step();
      cmp2("clr_bub", 32'(p_bub), 32'(n_bub), 0);
      cmp2("clr_stl", 32'(p_stl), 32'(n_stl), 0);
      clr_cnt = 0; flush = 0; valid = 1;
      step();
      cmp2("post_vld", 32'(p_vld), 32'(n_vld), 1);
      cmp2("post_rwr", 32'(p_rwr), 32'(n_rwr), 1);
      cmp2("post_bub", 32'(p_bub), 32'(n_bub), 0);
      reset = 1;
      #2;
      cmp2("rmid_vld", 32'(p_vld), 32'(n_vld), 1);
      @(posedge clock); #1;
      cmp("rpos_vld_pos", 32'(p_vld), 0);
      cmp("rpos_pc4_pos", p_pc4, 0);
      cmp("rpos_vld_neg", 32'(n_vld), 1);
      cmp("rpos_pc4_neg", n_pc4, 32'h8);
      reset = 0;
      @(negedge clock); #1;
      cmp("rneg_vld_neg", 32'(n_vld), 1);
      cmp("rneg_pc4_neg", n_pc4, 32'h8);
      PC4 = 32'h20;
      @(posedge clock); #1;
      cmp("edge_pc4_pos", p_pc4, 32'h20);
      cmp("edge_pc4_neg", n_pc4, 32'h8);
      cmp("edge_vld_pos", 32'(p_vld), 1);
      PC4 = 32'h30;
      @(negedge clock); #1;
      cmp("edge2_pc4_neg", n_pc4, 32'h30);
      cmp("edge2_pc4_pos", p_pc4, 32'h20);
      stall = 1; reset = 1;
      step();
      cmp2("rstl_vld", 32'(p_vld), 32'(n_vld), 0);
      cmp2("rstl_pc4", p_pc4, n_pc4, 0);
      cmp2("rstl_stl", 32'(p_stl), 32'(n_stl), 0);
      stall = 0; reset = 0; PC4 = 32'h40;
      step();
      cmp2("after_pc4", p_pc4, n_pc4, 32'h40);
      cmp2("after_vld", 32'(p_vld), 32'(n_vld), 1);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
